// File: rtl/cpl_bundle_writer.sv
// Bundle writer: streams payload words into a scratchpad slot, one write at a time, then pushes the bundle.
// Optional length header at index MAX_WORDS-1 is enabled by defining CPL_BUNDLE_LENGTH_HDR_EN.
module cpl_bundle_writer #(
  parameter int MAX_WORDS = 32
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [31:0] iWordData,
  input  logic        iWordValid,
  input  logic        iWordLast,
  output logic        oWordReady,
  output logic [31:0] oCPLWriteAddress,
  output logic [31:0] oCPLWriteData,
  output logic        oCPLWriteValid,
  input  logic        iCPLWriteAck,
  output logic        oCPLPushBundleValid,
  input  logic        iCPLPushBundleReady,
  output logic        oOverflow,
  output logic [5:0]  oWordCount,
  output logic [15:0] oBundleCount
);

  localparam int ADDR_BITS = $clog2(MAX_WORDS);

`ifdef CPL_BUNDLE_LENGTH_HDR_EN
  localparam logic [5:0] CAPACITY = 6'(MAX_WORDS - 1);
  localparam logic [ADDR_BITS-1:0] HDR_INDEX = ADDR_BITS'(MAX_WORDS - 1);
`else
  localparam logic [5:0] CAPACITY = 6'(MAX_WORDS);
`endif

  typedef enum logic [1:0] {
    S_ACCEPT = 2'd0,
    S_WRITE  = 2'd1,
    S_PUSH   = 2'd2
`ifdef CPL_BUNDLE_LENGTH_HDR_EN
    ,
    S_HDR    = 2'd3
`endif
  } state_t;

  state_t stateR;
  logic   lastR;
  logic   acceptS;

  function automatic logic [31:0] wordAddress(input logic [ADDR_BITS-1:0] index);
    return {{(32 - ADDR_BITS - 2){1'b0}}, index, 2'b00};
  endfunction

  // Ready is a pure state decode, forced low while reset is held.
  assign oWordReady = (stateR == S_ACCEPT) && !iReset;
  assign acceptS    = oWordReady && iWordValid;

  // Bundle sequencer: accept, write with ack handshake, optional header, push.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      stateR              <= S_ACCEPT;
      lastR               <= 1'b0;
      oCPLWriteAddress    <= 32'd0;
      oCPLWriteData       <= 32'd0;
      oCPLWriteValid      <= 1'b0;
      oCPLPushBundleValid <= 1'b0;
      oOverflow           <= 1'b0;
      oWordCount          <= 6'd0;
      oBundleCount        <= 16'd0;
    end else begin
      case (stateR)
        S_ACCEPT: begin
          if (acceptS) begin
            if (oWordCount < CAPACITY) begin
              oCPLWriteAddress <= wordAddress(oWordCount[ADDR_BITS-1:0]);
              oCPLWriteData    <= iWordData;
              oCPLWriteValid   <= 1'b1;
              lastR            <= iWordLast;
              stateR           <= S_WRITE;
            end else begin
              // Overflow word is dropped; the count stays saturated at capacity.
              oOverflow <= 1'b1;
              if (iWordLast) begin
`ifdef CPL_BUNDLE_LENGTH_HDR_EN
                stateR <= S_HDR;
`else
                oCPLPushBundleValid <= 1'b1;
                stateR              <= S_PUSH;
`endif
              end else begin
                stateR <= S_ACCEPT;
              end
            end
          end else begin
            stateR <= S_ACCEPT;
          end
        end
        S_WRITE: begin
          if (iCPLWriteAck) begin
            oCPLWriteValid <= 1'b0;
            oWordCount     <= oWordCount + 6'd1;
            if (lastR) begin
`ifdef CPL_BUNDLE_LENGTH_HDR_EN
              stateR <= S_HDR;
`else
              oCPLPushBundleValid <= 1'b1;
              stateR              <= S_PUSH;
`endif
            end else begin
              stateR <= S_ACCEPT;
            end
          end else begin
            stateR <= S_WRITE;
          end
        end
`ifdef CPL_BUNDLE_LENGTH_HDR_EN
        S_HDR: begin
          // First cycle loads the header from the settled count, then waits for its ack.
          if (!oCPLWriteValid) begin
            oCPLWriteAddress <= wordAddress(HDR_INDEX);
            oCPLWriteData    <= {oOverflow, 25'd0, oWordCount};
            oCPLWriteValid   <= 1'b1;
          end else if (iCPLWriteAck) begin
            oCPLWriteValid      <= 1'b0;
            oCPLPushBundleValid <= 1'b1;
            stateR              <= S_PUSH;
          end else begin
            stateR <= S_HDR;
          end
        end
`endif
        S_PUSH: begin
          if (iCPLPushBundleReady) begin
            oCPLPushBundleValid <= 1'b0;
            oBundleCount        <= oBundleCount + 16'd1;
            oWordCount          <= 6'd0;
            oOverflow           <= 1'b0;
            stateR              <= S_ACCEPT;
          end else begin
            stateR <= S_PUSH;
          end
        end
        default: begin
          oCPLWriteValid      <= 1'b0;
          oCPLPushBundleValid <= 1'b0;
          stateR              <= S_ACCEPT;
        end
      endcase
    end
  end

endmodule
